axi_lite_cmd_master: RTL
========================

// Module: axi_lite_cmd_master
// PURPOSE
// - AXI4-Lite initiator that turns single-word user commands into one AXI4-Lite write or read transaction.
// - Drives the PS/PL register slaves (ADC gain/offset/freq/size banks) from PL-side sequencers without CPU involvement.
// - One outstanding transaction at a time; the result is returned as a one-cycle response pulse.
// PARAMETERS
// - C_M_AXI_ADDR_WIDTH  5   byte-address width; bits [1:0] are driven as 0.
// - C_M_AXI_DATA_WIDTH  32  data width; only 32 is supported.
// PORTS
// - M_AXI_ACLK     in   1   single clock; all logic is on its rising edge
// - M_AXI_ARESET   in   1   synchronous reset, active-high
// - i_cmd_valid    in   1   command request
// - o_cmd_ready    out  1   1 in IDLE only; command is accepted when valid&&ready
// - i_cmd_wr       in   1   1 = write, 0 = read
// - i_cmd_addr     in   AW  byte address, word-aligned
// - i_cmd_wdata    in   32  write data
// - i_cmd_wstrb    in   4   write byte strobes
// - o_rsp_valid    out  1   one-cycle pulse: transaction complete
// - o_rsp_rdata    out  32  read data (write: 0); holds until the next response
// - o_rsp_resp     out  2   BRESP/RRESP captured from the slave
// - o_rsp_mismatch out  1   read-back mismatch flag (see CONFIGURATION; 0 without the macro)
// - M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY,
//   ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master; *PROT = 3'b000
// BEHAVIOUR
// - Reset values: every VALID/READY output = 0, o_cmd_ready = 1, o_rsp_* = 0, addr/data/strb outputs = 0, state = IDLE.
// - Reset mid-transaction: return to IDLE in the next cycle and drop all valids. The slave is assumed to be reset with the same reset.
// - IDLE: on accept, register addr/wdata/wstrb. A write goes to WR; a read goes to RD_A. o_cmd_ready drops in the cycle after accept.
// - WR: AWVALID and WVALID rise together in the first cycle after accept.
//   - Each valid drops independently after its own handshake (xVALID && xREADY).
//   - When both handshakes are done (same cycle or different cycles), go to WR_B.
// - WR_B: BREADY = 1. On BVALID, capture BRESP and go to DONE.
// - RD_A: ARVALID = 1 until ARREADY, then go to RD_D.
// - RD_D: RREADY = 1. On RVALID, capture RDATA/RRESP and go to DONE.
// - DONE: o_rsp_valid = 1 for exactly one cycle, then IDLE.
//   - o_cmd_ready returns to 1 in the IDLE cycle after DONE.
//   - A new command cannot be accepted in the same cycle as o_rsp_valid.
// - VALIDs are never deasserted before their handshake and never depend combinationally on READY.
//   Address, data and strobes are stable while VALID is high.
// - No timeouts: a non-responding slave stalls the block indefinitely.
// - Latency: with a slave that answers in 1 cycle, a write takes at most 4 cycles and a read 4 cycles from accept to o_rsp_valid.
// - i_cmd_* is ignored outside IDLE. o_rsp_resp is passed through as captured and is not interpreted.
// CONFIGURATION
// - Macro AXI_CMD_WR_VERIFY_EN.
// - Defined: after a write's B handshake, go to RD_A at the same address instead of DONE.
//   - The read data is compared with the written data on strobed bytes only.
//   - o_rsp_mismatch = 1 on any difference.
//   - o_rsp_rdata = read-back value.
//   - o_rsp_resp = BRESP if BRESP != 0, else RRESP.
//   - Plain reads: o_rsp_mismatch = 0.
// - Undefined: writes go straight WR_B -> DONE; o_rsp_mismatch is tied to 0.
// TESTING
// - Write addr 0x0C, data 0x0000_00F0, strb 0xF, zero-wait slave ->
//   - AW and W in the same cycle
//   - o_rsp_valid pulse with resp 0
//   - slave reg3 = 0xF0.
// - Slave raises WREADY 3 cycles before AWREADY -> WVALID drops alone; AWVALID held; a single B; one o_rsp_valid.
// - Read addr 0x00 while slave reg0 = 0x1234_5678 with RVALID delayed 5 cycles ->
//   - RREADY held throughout
//   - o_rsp_rdata = 0x1234_5678
// - i_cmd_valid held high continuously ->
//   - exactly one accept per transaction
//   - o_cmd_ready = 0 from accept through the o_rsp_valid cycle
// - M_AXI_ARESET pulsed while in WR_B -> next cycle all valids = 0, o_cmd_ready = 1, no o_rsp_valid.
// - VERIFY_EN: write 0xAABB_CCDD, strb 0x3, to a slave that reads back 0x0000_CCDD -> o_rsp_mismatch = 0.
//   Same write with read-back 0x0000_CCDE -> o_rsp_mismatch = 1.

Source files
------------

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: each accepted user command becomes one write or read transaction.
// Optional write read-back verification is enabled by defining AXI_CMD_WR_VERIFY_EN.
module axi_lite_cmd_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 5,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    input  logic                              i_cmd_valid,
    output logic                              o_cmd_ready,
    input  logic                              i_cmd_wr,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     i_cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     i_cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   i_cmd_wstrb,
    output logic                              o_rsp_valid,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     o_rsp_rdata,
    output logic [1:0]                        o_rsp_resp,
    output logic                              o_rsp_mismatch,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WR_B, S_RD_A, S_RD_D, S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic            awvalid_reg, wvalid_reg;
    logic [AW-1:2]   addr_reg;
    logic [DW-1:0]   wdata_reg;
    logic [SW-1:0]   wstrb_reg;
    logic [DW-1:0]   rdata_reg;
    logic [1:0]      resp_reg;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^i_cmd_addr[1:0];

`ifdef AXI_CMD_WR_VERIFY_EN
    logic            verify_rd_reg;
    logic            mismatch_reg;
    logic [1:0]      bresp_reg;
    logic [DW-1:0]   strb_mask;

    genvar gi;
    generate
        for (gi = 0; gi < SW; gi++) begin : g_mask
            assign strb_mask[gi*8 +: 8] = {8{wstrb_reg[gi]}};
        end
    endgenerate

    assign o_rsp_mismatch = mismatch_reg;
`else
    assign o_rsp_mismatch = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (i_cmd_valid) state_next = i_cmd_wr ? S_WR : S_RD_A;
            // Each channel is finished once its valid is already low or handshakes now
            S_WR: if ((!awvalid_reg || M_AXI_AWREADY) && (!wvalid_reg || M_AXI_WREADY))
                      state_next = S_WR_B;
`ifdef AXI_CMD_WR_VERIFY_EN
            S_WR_B: if (M_AXI_BVALID) state_next = S_RD_A;
`else
            S_WR_B: if (M_AXI_BVALID) state_next = S_DONE;
`endif
            S_RD_A: if (M_AXI_ARREADY) state_next = S_RD_D;
            S_RD_D: if (M_AXI_RVALID) state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_reg     <= S_IDLE;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            rdata_reg     <= '0;
            resp_reg      <= '0;
`ifdef AXI_CMD_WR_VERIFY_EN
            verify_rd_reg <= 1'b0;
            mismatch_reg  <= 1'b0;
            bresp_reg     <= '0;
`endif
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: if (i_cmd_valid) begin
                    addr_reg    <= i_cmd_addr[AW-1:2];
                    wdata_reg   <= i_cmd_wdata;
                    wstrb_reg   <= i_cmd_wstrb;
                    awvalid_reg <= i_cmd_wr;
                    wvalid_reg  <= i_cmd_wr;
`ifdef AXI_CMD_WR_VERIFY_EN
                    verify_rd_reg <= i_cmd_wr;
`endif
                end
                S_WR: begin
                    if (M_AXI_AWREADY) awvalid_reg <= 1'b0;
                    if (M_AXI_WREADY)  wvalid_reg  <= 1'b0;
                end
                S_WR_B: if (M_AXI_BVALID) begin
`ifdef AXI_CMD_WR_VERIFY_EN
                    bresp_reg <= M_AXI_BRESP;
`else
                    resp_reg  <= M_AXI_BRESP;
                    rdata_reg <= '0;
`endif
                end
                S_RD_D: if (M_AXI_RVALID) begin
                    rdata_reg <= M_AXI_RDATA;
`ifdef AXI_CMD_WR_VERIFY_EN
                    // A write error outranks whatever the read-back reported
                    if (verify_rd_reg) begin
                        resp_reg     <= (bresp_reg != 2'b00) ? bresp_reg : M_AXI_RRESP;
                        mismatch_reg <= |((M_AXI_RDATA ^ wdata_reg) & strb_mask);
                    end else begin
                        resp_reg     <= M_AXI_RRESP;
                        mismatch_reg <= 1'b0;
                    end
`else
                    resp_reg <= M_AXI_RRESP;
`endif
                end
                default: ;
            endcase
        end
    end

    assign o_cmd_ready   = (state_reg == S_IDLE);
    assign o_rsp_valid   = (state_reg == S_DONE);
    assign o_rsp_rdata   = rdata_reg;
    assign o_rsp_resp    = resp_reg;

    assign M_AXI_AWADDR  = {addr_reg, 2'b00};
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_reg;
    assign M_AXI_WDATA   = wdata_reg;
    assign M_AXI_WSTRB   = wstrb_reg;
    assign M_AXI_WVALID  = wvalid_reg;
    assign M_AXI_BREADY  = (state_reg == S_WR_B);
    assign M_AXI_ARADDR  = {addr_reg, 2'b00};
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = (state_reg == S_RD_A);
    assign M_AXI_RREADY  = (state_reg == S_RD_D);
endmodule
